ysyx_22050078_wb_arbiter: RTL and testbench
===========================================

# ysyx_22050078_wb_arbiter

Write-back arbiter and register scoreboard for the integer register file. Shares the regfile's single write port between the EXU result path and the LSU load-return path using a fair round-robin grant. Drives the regfile write port through a registered stage. Tracks a pending-write bit per architectural register so the decode/bypass logic can stall on RAW and WAW hazards.

## Interface
Parameters:
- CPU_WIDTH, 64, data width of every write-back value
- REG_ADDRW, 5, register address width (32 registers)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_exu_valid  in  1  EXU has a write-back ready
- i_exu_rd  in  REG_ADDRW  EXU destination register
- i_exu_data  in  CPU_WIDTH  EXU result
- o_exu_ready  out  1  EXU request accepted this cycle
- i_lsu_valid  in  1  LSU has load data ready
- i_lsu_rd  in  REG_ADDRW  LSU destination register
- i_lsu_data  in  CPU_WIDTH  LSU load data
- o_lsu_ready  out  1  LSU request accepted this cycle
- i_issue_valid  in  1  decode issuing an instruction that writes rd
- i_issue_rd  in  REG_ADDRW  destination of issuing instruction
- o_issue_ready  out  1  issue may proceed (no WAW on i_issue_rd)
- i_rs1_addr, i_rs2_addr  in  REG_ADDRW  source addresses being decoded
- o_rs1_busy, o_rs2_busy  out  1  source has an uncommitted write pending
- o_wen  out  1  regfile write enable
- o_waddr  out  REG_ADDRW  regfile write address
- o_wdata  out  CPU_WIDTH  regfile write data

## Operation
- Grant: exactly one requester per cycle. Only one valid -> that one is granted. Both valid -> round-robin; the requester not granted most recently wins. The last-grant flag updates only on a grant.
- Handshake: a transfer occurs when valid && ready in the same cycle. o_exu_ready/o_lsu_ready are combinational from valids and the last-grant flag. They never depend on the issue inputs. A requester holds valid, rd and data stable until ready.
- The granted request is registered into o_wen/o_waddr/o_wdata. With no grant, o_wen=0 next cycle, and o_waddr/o_wdata hold their previous values.
- Writes to x0 are accepted (ready=1) but produce o_wen=0.
- Scoreboard: pend[31:0].
  - Set pend[i_issue_rd] when i_issue_valid && o_issue_ready && i_issue_rd!=0.
  - Clear pend[o_waddr] on an edge where o_wen=1.
  - pend[0] is always 0.
- Simultaneous set and clear of the same index -> set wins.
- o_issue_ready = ~pend[i_issue_rd]. This blocks WAW; x0 is always ready.
- o_rsN_busy = pend[i_rsN_addr]. This includes the cycle o_wen=1 for that register, because the regfile has not yet been written.
- A write-back to a register with pend=0 is legal (no assertion); it writes normally, and its clear has no effect.

## Timing
- Reset (async, rst_n=0): o_wen=0, o_waddr=0, o_wdata=0, pend=0, last-grant=LSU (so EXU wins the first tie). Ready outputs remain combinational during reset and are 0 while both valids are 0.
- Latency from accept edge to regfile commit: 2 edges.
  - Edge 1 (accept) registers o_wen/o_waddr/o_wdata.
  - Edge 2 (o_wen=1) writes the regfile and clears pend.
  - o_rsN_busy falls in the cycle after edge 2.
- Throughput: one write-back per cycle; a continuous contended stream alternates EXU, LSU, EXU, ...
- Reset asserted mid-operation: in-flight write is dropped (o_wen forced 0 immediately) and all pending bits clear; upstream is flushed by the same reset.

## Structure
- Shared package/defines: CPU_WIDTH, REG_ADDRW, requester encoding (WB_SRC_EXU=0, WB_SRC_LSU=1).
- One natural sub-module: ysyx_22050078_rr_arb2, a 2-way round-robin arbiter with valid in, grant out and a last-grant register.
- Scoreboard and output register stay in this top module.

## Test plan
- Reset, then EXU valid rd=5 data=0x11 alone -> o_exu_ready=1 same cycle; next cycle o_wen=1, o_waddr=5, o_wdata=0x11.
- Both valid every cycle, EXU rd=1 and LSU rd=2, for 4 cycles -> grants EXU, LSU, EXU, LSU; losing side sees ready=0.
- Issue rd=7, then a second issue rd=7 -> second gets o_issue_ready=0. With i_rs1_addr=7, o_rs1_busy=1 until the cycle after the o_wen=1 edge for rd 7, then 0.
- LSU write rd=0 data=0xFF -> o_lsu_ready=1, o_wen stays 0; issue rd=0 -> o_issue_ready=1 and pend[0] stays 0.
- In the same cycle, issue rd=3 while o_wen=1 with o_waddr=3 -> pend[3]=1 afterwards (set wins).
- Assert rst_n=0 while o_wen=1 and pend nonzero -> o_wen=0 immediately, all busy outputs 0; after release, EXU wins the first tie.

Source files
------------

// File: rtl/ysyx_22050078_wb_pkg.sv
// Shared definitions for the write-back arbiter: datapath widths and the
// encoding used to name the two write-back requesters.
package ysyx_22050078_wb_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int REG_ADDRW = 5;

  // Bit positions in the arbiter request/grant vectors follow this encoding.
  typedef enum logic {
    WB_SRC_EXU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/ysyx_22050078_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that was not granted
// most recently wins; the last-grant register only moves on a grant.
module ysyx_22050078_rr_arb2
  import ysyx_22050078_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e last_q;

  always_comb begin
    gnt = 2'b00;
    if (req[WB_SRC_EXU] && req[WB_SRC_LSU]) begin
      if (last_q == WB_SRC_LSU) gnt[WB_SRC_EXU] = 1'b1;
      else                      gnt[WB_SRC_LSU] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // Reset to LSU so the EXU wins the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= WB_SRC_LSU;
    end else if (gnt[WB_SRC_EXU]) begin
      last_q <= WB_SRC_EXU;
    end else if (gnt[WB_SRC_LSU]) begin
      last_q <= WB_SRC_LSU;
    end
  end

endmodule

// File: rtl/ysyx_22050078_wb_arbiter.sv
// Write-back arbiter: shares the regfile write port between EXU and LSU,
// registers the granted write, and keeps a pending-write bit per register.
module ysyx_22050078_wb_arbiter
  import ysyx_22050078_wb_pkg::*;
#(
  parameter int CPU_WIDTH = ysyx_22050078_wb_pkg::CPU_WIDTH,
  parameter int REG_ADDRW = ysyx_22050078_wb_pkg::REG_ADDRW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_exu_valid,
  input  logic [REG_ADDRW-1:0] i_exu_rd,
  input  logic [CPU_WIDTH-1:0] i_exu_data,
  output logic                 o_exu_ready,
  input  logic                 i_lsu_valid,
  input  logic [REG_ADDRW-1:0] i_lsu_rd,
  input  logic [CPU_WIDTH-1:0] i_lsu_data,
  output logic                 o_lsu_ready,
  input  logic                 i_issue_valid,
  input  logic [REG_ADDRW-1:0] i_issue_rd,
  output logic                 o_issue_ready,
  input  logic [REG_ADDRW-1:0] i_rs1_addr,
  input  logic [REG_ADDRW-1:0] i_rs2_addr,
  output logic                 o_rs1_busy,
  output logic                 o_rs2_busy,
  output logic                 o_wen,
  output logic [REG_ADDRW-1:0] o_waddr,
  output logic [CPU_WIDTH-1:0] o_wdata
);

  localparam int NREGS = 1 << REG_ADDRW;

  // Handshake: a transfer happens on any edge where valid && ready. The
  // requester holds valid/rd/data stable until ready; ready depends only on
  // the two valids and the last-grant state, never on the issue inputs.
  logic [1:0]           req;
  logic [1:0]           gnt;
  logic                 any_gnt;
  logic [REG_ADDRW-1:0] sel_rd;
  logic [CPU_WIDTH-1:0] sel_data;

  assign req = {i_lsu_valid, i_exu_valid};

  ysyx_22050078_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign o_exu_ready = gnt[WB_SRC_EXU];
  assign o_lsu_ready = gnt[WB_SRC_LSU];
  assign any_gnt     = |gnt;

  always_comb begin
    sel_rd   = i_exu_rd;
    sel_data = i_exu_data;
    if (gnt[WB_SRC_LSU]) begin
      sel_rd   = i_lsu_rd;
      sel_data = i_lsu_data;
    end
  end

  // x0 writes are accepted but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wen   <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      o_wen <= any_gnt && (sel_rd != '0);
      if (any_gnt) begin
        o_waddr <= sel_rd;
        o_wdata <= sel_data;
      end
    end
  end

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_set;
  logic [NREGS-1:0] pend_clr;
  logic [NREGS-1:0] pend_nxt;

  assign o_issue_ready = ~pend[i_issue_rd];
  assign o_rs1_busy    = pend[i_rs1_addr];
  assign o_rs2_busy    = pend[i_rs2_addr];

  // Set is applied after clear so a re-issue in the commit cycle stays pending.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (i_issue_valid && o_issue_ready && (i_issue_rd != '0)) pend_set[i_issue_rd] = 1'b1;
    if (o_wen) pend_clr[o_waddr] = 1'b1;
    pend_nxt    = (pend & ~pend_clr) | pend_set;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_22050078_wb_arbiter.sv
// Bench for the write-back arbiter: directed scenarios plus random traffic,
// checked against a behavioural model and an expected write-back queue.
module tb_ysyx_22050078_wb_arbiter;

  localparam int W = 5 + 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_exu_valid = 1'b0;
  logic [4:0]  i_exu_rd = '0;
  logic [63:0] i_exu_data = '0;
  logic        o_exu_ready;
  logic        i_lsu_valid = 1'b0;
  logic [4:0]  i_lsu_rd = '0;
  logic [63:0] i_lsu_data = '0;
  logic        o_lsu_ready;
  logic        i_issue_valid = 1'b0;
  logic [4:0]  i_issue_rd = '0;
  logic        o_issue_ready;
  logic [4:0]  i_rs1_addr = '0;
  logic [4:0]  i_rs2_addr = '0;
  logic        o_rs1_busy;
  logic        o_rs2_busy;
  logic        o_wen;
  logic [4:0]  o_waddr;
  logic [63:0] o_wdata;

  ysyx_22050078_wb_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_exu_valid   (i_exu_valid),
    .i_exu_rd      (i_exu_rd),
    .i_exu_data    (i_exu_data),
    .o_exu_ready   (o_exu_ready),
    .i_lsu_valid   (i_lsu_valid),
    .i_lsu_rd      (i_lsu_rd),
    .i_lsu_data    (i_lsu_data),
    .o_lsu_ready   (o_lsu_ready),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .o_issue_ready (o_issue_ready),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy),
    .o_wen         (o_wen),
    .o_waddr       (o_waddr),
    .o_wdata       (o_wdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Model state describes the DUT after the most recent rising edge.
  logic [W-1:0] exp_q[$];
  bit          last_was_lsu = 1'b1;
  bit [31:0]   pend_m = '0;
  bit          wen_m = 1'b0;
  bit [4:0]    waddr_m = '0;
  bit          exu_acc = 1'b0;
  bit          lsu_acc = 1'b0;
  bit          n_last = 1'b1;
  bit [31:0]   n_pend = '0;
  bit          n_wen = 1'b0;
  bit [4:0]    n_waddr = '0;
  bit          n_push = 1'b0;
  logic [W-1:0] n_entry = '0;
  bit          m_ir;
  logic [4:0]  m_rd;
  logic [63:0] m_data;

  always @(negedge rst_n) begin
    last_was_lsu = 1'b1;
    pend_m       = '0;
    wen_m        = 1'b0;
    waddr_m      = '0;
    exp_q.delete();
  end

  always @(negedge clk) begin
    exu_acc = i_exu_valid && (!i_lsu_valid || last_was_lsu);
    lsu_acc = i_lsu_valid && (!i_exu_valid || !last_was_lsu);
    m_ir    = (i_issue_rd == 5'd0) || !pend_m[i_issue_rd];
    check("exu_ready",   64'(o_exu_ready),   64'(exu_acc));
    check("lsu_ready",   64'(o_lsu_ready),   64'(lsu_acc));
    check("issue_ready", 64'(o_issue_ready), 64'(m_ir));
    check("rs1_busy",    64'(o_rs1_busy),    64'(pend_m[i_rs1_addr]));
    check("rs2_busy",    64'(o_rs2_busy),    64'(pend_m[i_rs2_addr]));
    check("wen",         64'(o_wen),         64'(wen_m));
    n_pend = pend_m;
    if (wen_m) n_pend[waddr_m] = 1'b0;
    if (i_issue_valid && m_ir && i_issue_rd != 5'd0) n_pend[i_issue_rd] = 1'b1;
    n_wen   = 1'b0;
    n_push  = 1'b0;
    n_last  = last_was_lsu;
    n_waddr = waddr_m;
    if (exu_acc || lsu_acc) begin
      m_rd    = exu_acc ? i_exu_rd : i_lsu_rd;
      m_data  = exu_acc ? i_exu_data : i_lsu_data;
      n_last  = lsu_acc;
      n_waddr = m_rd;
      if (m_rd != 5'd0) begin
        n_wen   = 1'b1;
        n_push  = 1'b1;
        n_entry = {m_rd, m_data};
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      last_was_lsu = n_last;
      pend_m       = n_pend;
      wen_m        = n_wen;
      waddr_m      = n_waddr;
      if (n_push) exp_q.push_back(n_entry);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("wen_in_reset", 64'(o_wen), 64'd0);
    end else if (o_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb actual=addr %0d data %0h required=no write t=%0t",
                 o_waddr, o_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_addr", 64'(o_waddr), 64'(mon_e[68:64]));
        check("wb_data", o_wdata, mon_e[63:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exu(input bit v, input logic [4:0] rd, input logic [63:0] d);
    i_exu_valid = v;
    i_exu_rd    = rd;
    i_exu_data  = d;
  endtask

  task automatic set_lsu(input bit v, input logic [4:0] rd, input logic [63:0] d);
    i_lsu_valid = v;
    i_lsu_rd    = rd;
    i_lsu_data  = d;
  endtask

  task automatic set_issue(input bit v, input logic [4:0] rd);
    i_issue_valid = v;
    i_issue_rd    = rd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wen",   64'(o_wen),   64'd0);
    check("reset_waddr", 64'(o_waddr), 64'd0);
    check("reset_wdata", o_wdata,      64'd0);
    check("reset_ready", 64'(o_exu_ready | o_lsu_ready), 64'd0);
    rst_n = 1'b1;
    step();

    // Single EXU write-back.
    set_exu(1'b1, 5'd5, 64'h11);
    #1 check("t1_exu_ready", 64'(o_exu_ready), 64'd1);
    step();
    set_exu(1'b0, 5'd0, 64'd0);
    check("t1_wen",   64'(o_wen),   64'd1);
    check("t1_waddr", 64'(o_waddr), 64'd5);
    check("t1_wdata", o_wdata,      64'h11);
    step();

    // Contended stream alternates starting with EXU after reset.
    do_reset();
    set_exu(1'b1, 5'd1, 64'hA1);
    set_lsu(1'b1, 5'd2, 64'hB2);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_exu_ready", 64'(o_exu_ready), 64'(i % 2 == 0));
      check("t2_lsu_ready", 64'(o_lsu_ready), 64'(i % 2 == 1));
      step();
    end
    set_exu(1'b0, 5'd0, 64'd0);
    set_lsu(1'b0, 5'd0, 64'd0);
    step();
    step();

    // WAW block on rd 7 and busy window until commit.
    set_issue(1'b1, 5'd7);
    #1 check("t3_issue_first", 64'(o_issue_ready), 64'd1);
    step();
    #1 check("t3_issue_second", 64'(o_issue_ready), 64'd0);
    step();
    set_issue(1'b0, 5'd0);
    i_rs1_addr = 5'd7;
    set_exu(1'b1, 5'd7, 64'h77);
    #1 check("t3_busy_before", 64'(o_rs1_busy), 64'd1);
    step();
    set_exu(1'b0, 5'd0, 64'd0);
    check("t3_busy_wen_cycle", 64'(o_rs1_busy), 64'd1);
    check("t3_wen",            64'(o_wen),      64'd1);
    step();
    check("t3_busy_after", 64'(o_rs1_busy), 64'd0);

    // x0 write and x0 issue.
    set_lsu(1'b1, 5'd0, 64'hFF);
    #1 check("t4_lsu_ready", 64'(o_lsu_ready), 64'd1);
    step();
    set_lsu(1'b0, 5'd0, 64'd0);
    check("t4_wen_x0", 64'(o_wen), 64'd0);
    set_issue(1'b1, 5'd0);
    #1 check("t4_issue_x0", 64'(o_issue_ready), 64'd1);
    step();
    set_issue(1'b0, 5'd0);
    i_rs1_addr = 5'd0;
    #1 check("t4_busy_x0", 64'(o_rs1_busy), 64'd0);

    // Issue rd 3 in the cycle its (unpending) write commits: set wins.
    set_exu(1'b1, 5'd3, 64'h33);
    step();
    set_exu(1'b0, 5'd0, 64'd0);
    check("t5_wen",   64'(o_wen),   64'd1);
    check("t5_waddr", 64'(o_waddr), 64'd3);
    set_issue(1'b1, 5'd3);
    #1 check("t5_issue_ready", 64'(o_issue_ready), 64'd1);
    step();
    set_issue(1'b0, 5'd0);
    i_rs1_addr = 5'd3;
    #1 check("t5_pend_set_wins", 64'(o_rs1_busy), 64'd1);

    // Reset while a write is in flight and pending bits are set.
    set_issue(1'b1, 5'd4);
    set_exu(1'b1, 5'd5, 64'h55);
    step();
    set_issue(1'b0, 5'd0);
    set_exu(1'b0, 5'd0, 64'd0);
    i_rs1_addr = 5'd4;
    i_rs2_addr = 5'd3;
    #1;
    check("t6_wen_before", 64'(o_wen),      64'd1);
    check("t6_busy_before", 64'(o_rs1_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_wen_reset",  64'(o_wen),      64'd0);
    check("t6_rs1_reset",  64'(o_rs1_busy), 64'd0);
    check("t6_rs2_reset",  64'(o_rs2_busy), 64'd0);
    step();
    rst_n = 1'b1;
    set_exu(1'b1, 5'd6, 64'h66);
    set_lsu(1'b1, 5'd1, 64'h61);
    #1;
    check("t6_first_tie_exu", 64'(o_exu_ready), 64'd1);
    check("t6_first_tie_lsu", 64'(o_lsu_ready), 64'd0);
    step();
    set_exu(1'b0, 5'd0, 64'd0);

    // Random traffic: requesters hold until accepted, issue probes every cycle.
    for (int c = 0; c < 2000; c++) begin
      if (!i_exu_valid || exu_acc)
        set_exu($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom});
      if (!i_lsu_valid || lsu_acc)
        set_lsu($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom});
      set_issue($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
      i_rs1_addr = 5'($urandom_range(0, 7));
      i_rs2_addr = 5'($urandom_range(0, 7));
      step();
    end

    set_exu(1'b0, 5'd0, 64'd0);
    set_lsu(1'b0, 5'd0, 64'd0);
    set_issue(1'b0, 5'd0);
    repeat (4) step();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
